// File: rtl/echo_delay_proc_if.sv
// Sample stream interface for echo_delay_proc: input strobe, per-sample
// control fields and the processed output strobe.
interface echo_delay_proc_if #(
   parameter int DW = 10,
   parameter int AW = 13
);
   logic          data_valid;
   logic [DW-1:0] data_in;
   logic [AW-1:0] delay;
   logic [1:0]    mode;
   logic [1:0]    gain;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          busy;

   modport master (
      output data_valid, data_in, delay, mode, gain,
      input  data_out, out_valid, busy
   );

   modport slave (
      input  data_valid, data_in, delay, mode, gain,
      output data_out, out_valid, busy
   );
endinterface

// File: rtl/echo_delay_proc.sv
// Audio delay / echo processor: circular sample buffer with bypass, pure
// delay, feed-forward and feedback echo modes, four clocks per sample.
module echo_delay_proc #(
   parameter int DW = 10,
   parameter int AW = 13
) (
   input logic               sysclk,
   input logic               rst_n,
   echo_delay_proc_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
   typedef enum logic [1:0] {M_BYPASS, M_DELAY, M_FF, M_FB} mode_t;

   localparam int            DEPTH = 2**AW;
   localparam logic [DW-1:0] MID   = {1'b1, {(DW-1){1'b0}}};
   localparam logic [AW:0]   FULL  = {1'b1, {AW{1'b0}}};

   state_t               state;
   mode_t                mode_q;
   logic signed [DW-1:0] x_q;
   logic [AW-1:0]        delay_q;
   logic [1:0]           gain_q;
   logic [AW-1:0]        wr_ptr;
   logic [AW:0]          fill;
   logic signed [DW-1:0] ram_q;
   logic signed [DW-1:0] y_q;
   logic signed [DW-1:0] store_q;
   logic [DW-1:0]        data_out_q;
   logic                 out_valid_q;

   logic signed [DW-1:0] mem [DEPTH];

   logic [AW-1:0]        rd_addr;
   logic                 ram_we;
   logic signed [DW-1:0] d;
   logic signed [DW-1:0] shifted;
   logic signed [DW:0]   sum;
   logic signed [DW-1:0] sat;
   logic signed [DW-1:0] y_c;
   logic signed [DW-1:0] store_c;

   assign rd_addr = wr_ptr - delay_q;
   // An abandoned sample must never reach the buffer, so reset gates the write.
   assign ram_we  = rst_n && (state == WRITE);

   // NOTE: the buffer has no reset; clearing 2^AW words is impossible in one
   // cycle and unnecessary because fill masks every stale location.
   always_ff @(posedge sysclk) begin
      if (ram_we)
         mem[wr_ptr] <= store_q;
      if (state == READ)
         ram_q <= mem[rd_addr];
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      d = ram_q;
      if (delay_q == '0)
         d = (mode_q == M_FB) ? '0 : x_q;
      else if ({1'b0, delay_q} > fill)
         d = '0;
   end

   assign shifted = d >>> ({1'b0, gain_q} + 3'd1);
   assign sum     = {x_q[DW-1], x_q} + {shifted[DW-1], shifted};

   // Overflow shows as disagreement between the two top bits of the wide sum.
   always_comb begin
      sat = sum[DW-1:0];
      if (sum[DW] != sum[DW-1])
         sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   end

   always_comb begin
      y_c = sat;
      case (mode_q)
         M_BYPASS: y_c = x_q;
         M_DELAY:  y_c = d;
         default:  y_c = sat;
      endcase
      store_c = (mode_q == M_FB) ? y_c : x_q;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         fill        <= '0;
         data_out_q  <= MID;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.data_valid) begin
                  x_q     <= {~bus.data_in[DW-1], bus.data_in[DW-2:0]};
                  delay_q <= bus.delay;
                  mode_q  <= mode_t'(bus.mode);
                  gain_q  <= bus.gain;
                  state   <= READ;
               end
            end
            READ: state <= CALC;
            CALC: begin
               y_q     <= y_c;
               store_q <= store_c;
               state   <= WRITE;
            end
            WRITE: begin
               wr_ptr      <= wr_ptr + AW'(1);
               if (fill != FULL)
                  fill <= fill + (AW+1)'(1);
               data_out_q  <= {~y_q[DW-1], y_q[DW-2:0]};
               out_valid_q <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_echo_delay_proc.sv
// Directed bench for echo_delay_proc with a 16-deep buffer: every expected
// output below is hand-computed from the sample arithmetic.
module tb_echo_delay_proc;
   localparam int DW = 10;
   localparam int AW = 4;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   int   tests  = 0;
   int   fails  = 0;

   echo_delay_proc_if #(.DW(DW), .AW(AW)) bus ();

   echo_delay_proc #(.DW(DW), .AW(AW)) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );

   always #10 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst_n = 1'b0;
      bus.data_valid = 1'b0;
      @(negedge sysclk);
      rst_n = 1'b1;
   endtask

   // Sends one sample, scrambles the control fields once accepted, optionally
   // fires a strobe while busy, and checks latency and output value.
   task automatic send(input string tag, input int din, input int dly, input int md,
                       input int g, input int exp, input bit drop = 1'b0);
      int lat;
      lat = 0;
      @(negedge sysclk);
      bus.data_valid = 1'b1;
      bus.data_in    = din[DW-1:0];
      bus.delay      = dly[AW-1:0];
      bus.mode       = md[1:0];
      bus.gain       = g[1:0];
      @(negedge sysclk);
      bus.data_valid = 1'b0;
      bus.delay      = ~bus.delay;
      bus.mode       = ~bus.mode;
      bus.gain       = ~bus.gain;
      for (int n = 1; n <= 8; n++) begin
         @(negedge sysclk);
         if (drop && n == 1) begin
            bus.data_valid = 1'b1;
            bus.data_in    = '0;
         end else begin
            bus.data_valid = 1'b0;
         end
         if (bus.out_valid) begin
            lat = n;
            break;
         end
      end
      check({tag, "_lat"}, lat, 3);
      check(tag, bus.data_out, exp);
      if (drop) begin
         @(negedge sysclk);
         check({tag, "_drop"}, {bus.out_valid, bus.busy}, 0);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pd_in  [6] = '{512, 512, 612, 512, 512, 512};
      int pd_exp [6] = '{512, 512, 512, 512, 512, 612};
      int fb_exp [5] = '{768, 640, 576, 544, 528};

      bus.data_valid = 1'b0;
      bus.data_in    = '0;
      bus.delay      = '0;
      bus.mode       = '0;
      bus.gain       = '0;
      repeat (3) @(negedge sysclk);
      check("rst_data_out", bus.data_out, 512);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      rst_n = 1'b1;

      // Pure delay of 3 samples
      for (int i = 0; i < 6; i++)
         send($sformatf("pd%0d", i), pd_in[i], 3, 1, 0, pd_exp[i]);

      // Feed-forward echo, delay 2, gain 0
      do_reset();
      send("ff0", 712, 2, 2, 0, 712);
      send("ff1", 512, 2, 2, 0, 512);
      send("ff2", 512, 2, 2, 0, 612);

      // Positive saturation
      do_reset();
      send("sat0", 1023, 1, 2, 0, 1023);
      send("sat1", 1023, 1, 2, 0, 1023);

      // Feedback echo impulse response
      do_reset();
      send("fb0", 768, 1, 3, 0, fb_exp[0]);
      for (int i = 1; i < 5; i++)
         send($sformatf("fb%0d", i), 512, 1, 3, 0, fb_exp[i]);

      // Mixed modes, delay 0, larger gain, negative rounding and saturation, fill masking
      do_reset();
      send("byp",      300, 5, 0, 0, 300);
      send("ff_d0",    712, 0, 2, 1, 762);
      send("fb_d0",    712, 0, 3, 0, 712);
      send("ff_g3",    312, 1, 2, 3, 324);
      send("ff_g3neg", 512, 1, 2, 3, 499);
      send("pd_d5",    512, 5, 1, 0, 300);
      send("negmin",     0, 1, 2, 0, 0);
      send("negsat",     0, 1, 2, 0, 0);
      send("pd_d7",    512, 7, 1, 3, 712);
      send("pd_fill",  600, 10, 1, 0, 512);

      // Wrap-around on a 16-deep buffer with a dropped strobe mid-stream
      do_reset();
      for (int i = 0; i < 40; i++)
         send($sformatf("wrap%0d", i), 512 + i, 15, 1, 0,
              (i >= 15) ? 512 + i - 15 : 512, i == 20);
      send("full_d0", 100, 0, 1, 0, 100);
      send("full_d1", 512, 1, 1, 0, 100);

      // Reset asserted during WRITE abandons the sample
      @(negedge sysclk);
      bus.data_valid = 1'b1;
      bus.data_in    = 10'd900;
      bus.mode       = 2'b00;
      @(negedge sysclk);
      bus.data_valid = 1'b0;
      repeat (2) @(negedge sysclk);
      check("mid_busy", bus.busy, 1);
      rst_n = 1'b0;
      @(negedge sysclk);
      check("mid_data_out", bus.data_out, 512);
      check("mid_out_valid", bus.out_valid, 0);
      check("mid_busy_clr", bus.busy, 0);
      rst_n = 1'b1;
      send("post_rst0", 700, 1, 1, 0, 512);
      send("post_rst1", 512, 1, 1, 0, 700);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
